// File: rtl/neighbor_table_update.sv
// Writer side of the neighbor / known-sink tables: dedups each beacon against the
// stored IDs, appends when new, and commits the count word last.
module neighbor_table_update #(
  parameter int MAX_NEIGHBORS = 64,
  parameter int MAX_SINKS     = 32
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        beacon_valid,
  output logic        beacon_ready,
  input  logic [15:0] beacon_neighbor_id,
  input  logic [15:0] beacon_cluster_id,
  input  logic        beacon_is_sink,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic        wr_en,
  output logic [15:0] data_out,
  output logic        done,
  output logic        overflow
);

  localparam logic [15:0] SINK_BASE = 16'h0008;
  localparam logic [15:0] NBR_BASE  = 16'h0048;
  localparam logic [15:0] CID_BASE  = 16'h00C8;
  localparam logic [15:0] SCNT_ADDR = 16'h0688;
  localparam logic [15:0] NCNT_ADDR = 16'h068A;
  localparam logic [15:0] NMAX      = 16'(MAX_NEIGHBORS);
  localparam logic [15:0] SMAX      = 16'(MAX_SINKS);

  typedef enum logic [3:0] {
    IDLE, RD_NCNT, N_SCAN, N_END, N_WCID, N_WCNT,
    S_START, RD_SCNT, S_SCAN, S_END, S_WCNT, DONE
  } state_t;

  state_t      state_q;
  logic [15:0] id_q, cid_q, cnt_q, k_q;
  logic        sink_q, new_q, drop_q;
  logic [15:0] address_q, data_out_q;
  logic        wr_en_q, ready_q, done_q, overflow_q;

  function automatic logic [15:0] waddr(input logic [15:0] base, input logic [15:0] idx);
    return base + (idx << 1);
  endfunction

  // data_in lags address by a cycle, so every read address is issued one state
  // ahead of the state that consumes it (scan entry k+1 is fetched while k is compared).
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      cid_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      sink_q     <= 1'b0;
      new_q      <= 1'b0;
      drop_q     <= 1'b0;
      address_q  <= NCNT_ADDR;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (beacon_valid && ready_q) begin
          id_q      <= beacon_neighbor_id;
          cid_q     <= beacon_cluster_id;
          sink_q    <= beacon_is_sink;
          ready_q   <= 1'b0;
          address_q <= NBR_BASE;
          state_q   <= RD_NCNT;
        end
        RD_NCNT: begin
          cnt_q <= data_in;
          k_q   <= '0;
          if (data_in == 16'd0) begin
            wr_en_q    <= (NMAX != 16'd0);
            address_q  <= NBR_BASE;
            data_out_q <= id_q;
            state_q    <= N_END;
          end else begin
            address_q <= waddr(NBR_BASE, 16'd1);
            state_q   <= N_SCAN;
          end
        end
        N_SCAN: begin
          if (data_in == id_q) begin
            new_q      <= 1'b0;
            wr_en_q    <= 1'b1;
            address_q  <= waddr(CID_BASE, k_q);
            data_out_q <= cid_q;
            state_q    <= N_WCID;
          end else if (k_q + 16'd1 == cnt_q) begin
            wr_en_q    <= (cnt_q != NMAX);
            address_q  <= waddr(NBR_BASE, cnt_q);
            data_out_q <= id_q;
            state_q    <= N_END;
          end else begin
            k_q       <= k_q + 16'd1;
            address_q <= waddr(NBR_BASE, k_q + 16'd2);
          end
        end
        N_END: begin
          if (cnt_q == NMAX) begin
            drop_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            address_q <= SCNT_ADDR;
            state_q   <= S_START;
          end else begin
            new_q      <= 1'b1;
            wr_en_q    <= 1'b1;
            address_q  <= waddr(CID_BASE, cnt_q);
            data_out_q <= cid_q;
            state_q    <= N_WCID;
          end
        end
        N_WCID: begin
          if (new_q) begin
            wr_en_q    <= 1'b1;
            address_q  <= NCNT_ADDR;
            data_out_q <= cnt_q + 16'd1;
            state_q    <= N_WCNT;
          end else begin
            wr_en_q   <= 1'b0;
            address_q <= SCNT_ADDR;
            state_q   <= S_START;
          end
        end
        N_WCNT: begin
          wr_en_q   <= 1'b0;
          address_q <= SCNT_ADDR;
          state_q   <= S_START;
        end
        S_START: begin
          if (!sink_q) begin
            done_q     <= 1'b1;
            overflow_q <= drop_q;
            state_q    <= DONE;
          end else begin
            address_q <= SINK_BASE;
            state_q   <= RD_SCNT;
          end
        end
        RD_SCNT: begin
          cnt_q <= data_in;
          k_q   <= '0;
          if (data_in == 16'd0) begin
            wr_en_q    <= (SMAX != 16'd0);
            address_q  <= SINK_BASE;
            data_out_q <= id_q;
            state_q    <= S_END;
          end else begin
            address_q <= waddr(SINK_BASE, 16'd1);
            state_q   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (data_in == id_q) begin
            done_q     <= 1'b1;
            overflow_q <= drop_q;
            state_q    <= DONE;
          end else if (k_q + 16'd1 == cnt_q) begin
            wr_en_q    <= (cnt_q != SMAX);
            address_q  <= waddr(SINK_BASE, cnt_q);
            data_out_q <= id_q;
            state_q    <= S_END;
          end else begin
            k_q       <= k_q + 16'd1;
            address_q <= waddr(SINK_BASE, k_q + 16'd2);
          end
        end
        S_END: begin
          if (cnt_q == SMAX) begin
            drop_q     <= 1'b1;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b1;
            overflow_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            wr_en_q    <= 1'b1;
            address_q  <= SCNT_ADDR;
            data_out_q <= cnt_q + 16'd1;
            state_q    <= S_WCNT;
          end
        end
        S_WCNT: begin
          wr_en_q    <= 1'b0;
          done_q     <= 1'b1;
          overflow_q <= drop_q;
          state_q    <= DONE;
        end
        DONE: begin
          done_q     <= 1'b0;
          overflow_q <= 1'b0;
          drop_q     <= 1'b0;
          wr_en_q    <= 1'b0;
          ready_q    <= 1'b1;
          address_q  <= NCNT_ADDR;
          state_q    <= IDLE;
        end
        default: begin
          wr_en_q   <= 1'b0;
          ready_q   <= 1'b1;
          address_q <= NCNT_ADDR;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign beacon_ready = ready_q;
  assign address      = address_q;
  assign wr_en        = wr_en_q;
  assign data_out     = data_out_q;
  assign done         = done_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_neighbor_table_update.sv
// Directed bench for neighbor_table_update against a one-cycle-latency word memory.
module tb_neighbor_table_update;
  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic        beacon_valid = 1'b0;
  logic        beacon_ready;
  logic [15:0] beacon_neighbor_id = '0;
  logic [15:0] beacon_cluster_id  = '0;
  logic        beacon_is_sink     = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        done;
  logic        overflow;

  always #5 clock = ~clock;

  neighbor_table_update dut (
    .clock(clock), .nrst(nrst),
    .beacon_valid(beacon_valid), .beacon_ready(beacon_ready),
    .beacon_neighbor_id(beacon_neighbor_id), .beacon_cluster_id(beacon_cluster_id),
    .beacon_is_sink(beacon_is_sink),
    .data_in(data_in), .address(address), .wr_en(wr_en), .data_out(data_out),
    .done(done), .overflow(overflow)
  );

  // word memory plus a preload port so only this block ever writes mem
  logic [15:0] mem [0:1023] = '{default: 16'h0000};
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;
  logic [31:0] wlog [0:255];
  int          wcnt = 0;

  always @(posedge clock) begin
    data_in <= mem[address[10:1]];
    if (pre_we) mem[pre_a] <= pre_d;
    else if (wr_en) begin
      mem[address[10:1]] <= data_out;
      wlog[wcnt[7:0]]    <= {address, data_out};
      wcnt               <= wcnt + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  int wbase = 0;
  int lat;
  logic ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] baddr, input logic [15:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_a = baddr[10:1]; pre_d = d;
    @(posedge clock);
    #1 pre_we = 1'b0;
  endtask

  function automatic logic [15:0] peek(input logic [15:0] baddr);
    return mem[baddr[10:1]];
  endfunction

  task automatic send(input logic [15:0] id, input logic [15:0] c, input logic s);
    @(negedge clock);
    wbase = wcnt;
    beacon_neighbor_id = id; beacon_cluster_id = c; beacon_is_sink = s;
    beacon_valid = 1'b1;
    chk("ready_at_accept", 32'(beacon_ready), 32'd1);
    @(posedge clock);
    #1 beacon_valid = 1'b0;
  endtask

  // lat = index of the cycle (accept cycle = 0) in which done is high
  task automatic wait_done(output int l, output logic o);
    l = -1; o = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      if (done) begin l = n; o = overflow; break; end
    end
    chk("done_seen", 32'(l > 0), 32'd1);
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [15:0] a, input logic [15:0] d);
    chk(tag, wlog[8'(wbase + k)], {a, d});
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_ready",    32'(beacon_ready), 32'd1);
    chk("rst_wr_en",    32'(wr_en),        32'd0);
    chk("rst_address",  32'(address),      32'h068A);
    chk("rst_data_out", 32'(data_out),     32'd0);
    chk("rst_done",     32'(done),         32'd0);
    chk("rst_overflow", 32'(overflow),     32'd0);
    @(negedge clock) nrst = 1'b1;

    // new neighbor into empty tables
    send(16'h0005, 16'h0002, 1'b0);
    wait_done(lat, ov);
    chk("t1_latency", 32'(lat), 32'd6);
    chk("t1_overflow", 32'(ov), 32'd0);
    chk("t1_nwrites", 32'(wcnt - wbase), 32'd3);
    chk_wr("t1_wr0", 0, 16'h0048, 16'h0005);
    chk_wr("t1_wr1", 1, 16'h00C8, 16'h0002);
    chk_wr("t1_wr2", 2, 16'h068A, 16'h0001);
    @(negedge clock);
    chk("t1_ready_after", 32'(beacon_ready), 32'd1);

    // existing neighbor: cluster overwrite only
    poke(16'h068A, 16'd3);
    poke(16'h0048, 16'd7);
    poke(16'h004A, 16'd9);
    poke(16'h004C, 16'd5);
    poke(16'h00CA, 16'd0);
    send(16'd9, 16'd4, 1'b0);
    wait_done(lat, ov);
    chk("t2_overflow", 32'(ov), 32'd0);
    chk("t2_nwrites", 32'(wcnt - wbase), 32'd1);
    chk_wr("t2_wr0", 0, 16'h00CA, 16'h0004);
    chk("t2_ncount", 32'(peek(16'h068A)), 32'd3);

    // full neighbor table, new id dropped
    poke(16'h068A, 16'd64);
    for (int i = 0; i < 64; i++) poke(16'(16'h0048 + 2 * i), 16'(16'h1000 + i));
    send(16'h0100, 16'h0007, 1'b0);
    wait_done(lat, ov);
    chk("t3_latency", 32'(lat), 32'd68);
    chk("t3_overflow", 32'(ov), 32'd1);
    chk("t3_nwrites", 32'(wcnt - wbase), 32'd0);

    // sink already known: neighbor append only
    poke(16'h068A, 16'd0);
    poke(16'h0008, 16'h0011);
    poke(16'h0688, 16'd1);
    send(16'h0011, 16'h0001, 1'b1);
    wait_done(lat, ov);
    chk("t4_overflow", 32'(ov), 32'd0);
    chk("t4_nwrites", 32'(wcnt - wbase), 32'd3);
    chk_wr("t4_wr0", 0, 16'h0048, 16'h0011);
    chk_wr("t4_wr1", 1, 16'h00C8, 16'h0001);
    chk_wr("t4_wr2", 2, 16'h068A, 16'h0001);
    chk("t4_scount", 32'(peek(16'h0688)), 32'd1);

    // new sink: neighbor append then sink append, counts last
    poke(16'h068A, 16'd0);
    poke(16'h0688, 16'd0);
    poke(16'h0008, 16'd0);
    send(16'h0011, 16'h0001, 1'b1);
    wait_done(lat, ov);
    chk("t5_overflow", 32'(ov), 32'd0);
    chk("t5_nwrites", 32'(wcnt - wbase), 32'd5);
    chk_wr("t5_wr0", 0, 16'h0048, 16'h0011);
    chk_wr("t5_wr1", 1, 16'h00C8, 16'h0001);
    chk_wr("t5_wr2", 2, 16'h068A, 16'h0001);
    chk_wr("t5_wr3", 3, 16'h0008, 16'h0011);
    chk_wr("t5_wr4", 4, 16'h0688, 16'h0001);

    // reset while the clusterID write is on the bus
    poke(16'h068A, 16'd0);
    send(16'h0022, 16'h0006, 1'b0);
    repeat (3) @(negedge clock);
    chk("t6_pre_wr_en", 32'(wr_en), 32'd1);
    chk("t6_pre_addr", 32'(address), 32'h00C8);
    nrst = 1'b0;
    #1;
    chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t6_rst_ready", 32'(beacon_ready), 32'd1);
    @(negedge clock);
    nrst = 1'b1;
    chk("t6_nwrites", 32'(wcnt - wbase), 32'd1);
    chk("t6_ncount", 32'(peek(16'h068A)), 32'd0);
    send(16'h0022, 16'h0006, 1'b0);
    wait_done(lat, ov);
    chk("t6_re_latency", 32'(lat), 32'd6);
    chk("t6_re_nwrites", 32'(wcnt - wbase), 32'd3);
    chk("t6_re_ncount", 32'(peek(16'h068A)), 32'd1);
    chk("t6_re_cid", 32'(peek(16'h00C8)), 32'h0006);

    // id 0 matches stored entry; sink table full so the sink is dropped
    poke(16'h068A, 16'd1);
    poke(16'h0048, 16'h0000);
    poke(16'h0688, 16'd32);
    for (int i = 0; i < 32; i++) poke(16'(16'h0008 + 2 * i), 16'(16'h0200 + i));
    send(16'h0000, 16'h0003, 1'b1);
    wait_done(lat, ov);
    chk("t7_overflow", 32'(ov), 32'd1);
    chk("t7_nwrites", 32'(wcnt - wbase), 32'd1);
    chk_wr("t7_wr0", 0, 16'h00C8, 16'h0003);
    chk("t7_scount", 32'(peek(16'h0688)), 32'd32);
    @(negedge clock);
    chk("t7_overflow_pulse", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
